// File: rtl/sim_harness_pkg.sv
// sim_harness_pkg: shared FSM states, store size codes and the store strobe helper.
package sim_harness_pkg;
   typedef enum logic [1:0] {CLEAR, PROG, RUN, DONE} state_t;
   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;
   function automatic logic [3:0] base_strobe(input logic [1:0] size);
      return size == SB[1:0] ? 4'b0001 : size == SH[1:0] ? 4'b0011 : size == SW[1:0] ? 4'b1111 : 4'b0000;
   endfunction
endpackage

// File: rtl/store_merge.sv
// store_merge: aligns a byte/half/word store into the addressed word, dropping bytes past the word end.
module store_merge
   import sim_harness_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [1:0]  func3,
   input  logic [31:0] wdata,
   input  logic [31:0] old,
   output logic [31:0] merged,
   output logic        we
);
   logic [3:0]  strb;
   logic [31:0] data;
   assign strb = base_strobe(func3) << addr;
   assign data = wdata << {addr, 3'b000};
   assign we = |strb;
   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign merged[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
   end
endmodule

// File: rtl/sim_harness.sv
// sim_harness: memory, loader and result monitor wrapped around an external RV32 core.
module sim_harness
   import sim_harness_pkg::*;
#(
   parameter int          INST_MEM_ADDR_SIZE = 10,
   parameter int          DATA_MEM_ADDR_SIZE = 10,
   parameter logic [31:0] RESULT_ADDR        = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYCLES     = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_valid,
   output logic        prog_ready,
   input  logic [31:0] prog_data,
   input  logic        prog_sel,
   input  logic        prog_last,
   output logic        core_rst,
   input  logic [31:0] core_pc,
   output logic [31:0] core_instr,
   input  logic [31:0] core_mem_addr,
   input  logic [31:0] core_wdata,
   input  logic [2:0]  core_func3,
   input  logic        core_we,
   output logic [31:0] core_rdata,
   output logic        result_valid,
   output logic        result_passed,
   output logic        timeout,
   output logic        prog_overflow,
   output logic [31:0] cycle_count
);
   localparam int IA = INST_MEM_ADDR_SIZE - 2;
   localparam int DA = DATA_MEM_ADDR_SIZE - 2;
   localparam int CA = IA > DA ? IA : DA;
   state_t        state, state_nx;
   logic [CA-1:0] clr_idx;
   logic [IA-1:0] iptr;
   logic [DA-1:0] dptr;
   logic [31:0]   imem [2**IA];
   logic [31:0]   dmem [2**DA];
   logic [31:0]   merged;
   logic          merge_we, accept, is_result, expire, unused_pc;
   assign accept = state == PROG && prog_valid;
   assign is_result = core_we && core_mem_addr == RESULT_ADDR && core_func3 == SW;
   assign expire = cycle_count == 32'(TIMEOUT_CYCLES - 1);
   assign prog_ready = state == PROG;
   assign core_rst = state != RUN;
   assign core_instr = imem[core_pc[INST_MEM_ADDR_SIZE-1:2]];
   assign core_rdata = dmem[core_mem_addr[DATA_MEM_ADDR_SIZE-1:2]];
   assign unused_pc = ^{core_pc[31:INST_MEM_ADDR_SIZE], core_pc[1:0]};
   store_merge u_merge (
      .addr   (core_mem_addr[1:0]),
      .func3  (core_func3[1:0]),
      .wdata  (core_wdata),
      .old    (core_rdata),
      .merged (merged),
      .we     (merge_we)
   );
   always_comb begin
      state_nx = state;
      state_nx = (state == CLEAR && &clr_idx)          ? PROG :
                 (state == PROG && accept && prog_last) ? RUN  :
                 (state == RUN && (is_result || expire)) ? DONE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= CLEAR;
         clr_idx       <= '0;
         iptr          <= '0;
         dptr          <= '0;
         cycle_count   <= '0;
         result_valid  <= 1'b0;
         result_passed <= 1'b0;
         timeout       <= 1'b0;
         prog_overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) clr_idx <= clr_idx + CA'(1);
         if (accept && !prog_sel) iptr <= iptr + IA'(1);
         if (accept && prog_sel) dptr <= dptr + DA'(1);
         if (accept && (prog_sel ? &dptr : &iptr)) prog_overflow <= 1'b1;
         if (state == RUN) begin
            if (~&cycle_count) cycle_count <= cycle_count + 32'd1;
            // a result store on the expiry cycle takes priority over the watchdog
            if (is_result) begin
               result_valid  <= 1'b1;
               result_passed <= core_wdata == 32'd1;
            end else if (expire) begin
               timeout <= 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (state == CLEAR && (clr_idx >> IA) == '0) imem[clr_idx[IA-1:0]] <= '0;
      if (accept && !prog_sel) imem[iptr] <= prog_data;
   end
   always_ff @(posedge clk) begin
      if (state == CLEAR && (clr_idx >> DA) == '0) dmem[clr_idx[DA-1:0]] <= '0;
      if (accept && prog_sel) dmem[dptr] <= prog_data;
      if (state == RUN && core_we && merge_we && !is_result) dmem[core_mem_addr[DATA_MEM_ADDR_SIZE-1:2]] <= merged;
   end
endmodule

// File: tb/tb_sim_harness.sv
// tb_sim_harness: directed and randomized sessions checked against a behavioural harness model.
module tb_sim_harness;
   localparam int TO = 10;
   localparam int WORDS = 256;
   logic        clk = 0, rst_n = 0;
   logic        prog_valid = 0, prog_sel = 0, prog_last = 0, core_we = 0;
   logic [31:0] prog_data = 0, core_pc = 0, core_mem_addr = 0, core_wdata = 0;
   logic [2:0]  core_func3 = 0;
   logic        prog_ready, core_rst, result_valid, result_passed, timeout, prog_overflow;
   logic [31:0] core_instr, core_rdata, cycle_count;
   int          checks = 0, failures = 0;
   logic [31:0] im [WORDS];
   logic [31:0] dm [WORDS];
   int          ip, dp, cyc;
   bit          m_run, m_rv, m_rp, m_to, m_ovf;

   sim_harness #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_ready(prog_ready),
      .prog_data(prog_data), .prog_sel(prog_sel), .prog_last(prog_last), .core_rst(core_rst),
      .core_pc(core_pc), .core_instr(core_instr), .core_mem_addr(core_mem_addr),
      .core_wdata(core_wdata), .core_func3(core_func3), .core_we(core_we),
      .core_rdata(core_rdata), .result_valid(result_valid), .result_passed(result_passed),
      .timeout(timeout), .prog_overflow(prog_overflow), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_flags(input string tag);
      check({tag, "_ready"}, 32'(prog_ready), 0);
      check({tag, "_core_rst"}, 32'(core_rst), 1);
      check({tag, "_rvalid"}, 32'(result_valid), 0);
      check({tag, "_rpassed"}, 32'(result_passed), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
      check({tag, "_overflow"}, 32'(prog_overflow), 0);
      check({tag, "_cycles"}, cycle_count, 0);
   endtask

   task automatic start;
      int n;
      rst_n = 0;
      prog_valid = 0;
      prog_last = 0;
      core_we = 0;
      #1;
      check_idle_flags("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < WORDS; i++) begin
         im[i] = 0;
         dm[i] = 0;
      end
      ip = 0; dp = 0; cyc = 0;
      m_run = 0; m_rv = 0; m_rp = 0; m_to = 0; m_ovf = 0;
      n = 0;
      while (!prog_ready && n < 1000) begin
         tick();
         n++;
      end
      check("clear_len", 32'(n), 256);
   endtask

   task automatic beat(input bit sel, input logic [31:0] data, input bit last);
      prog_valid = 1;
      prog_sel = sel;
      prog_data = data;
      prog_last = last;
      tick();
      prog_valid = 0;
      prog_last = 0;
      if (sel) begin
         dm[dp] = data;
         dp = (dp + 1) % WORDS;
         if (dp == 0) m_ovf = 1;
      end else begin
         im[ip] = data;
         ip = (ip + 1) % WORDS;
         if (ip == 0) m_ovf = 1;
      end
      if (last) begin
         m_run = 1;
         check("core_rst_fall", 32'(core_rst), 0);
      end
   endtask

   task automatic store_ref(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
      int n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 0;
      int w = int'(a[9:2]);
      for (int b = 0; b < n; b++)
         if (int'(a[1:0]) + b < 4) dm[w][8*(int'(a[1:0]) + b) +: 8] = wd[8*b +: 8];
   endtask

   task automatic cycle(input bit we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] pc);
      core_we = we;
      core_mem_addr = a;
      core_func3 = f3;
      core_wdata = wd;
      core_pc = pc;
      #1;
      check("rdata", core_rdata, dm[a[9:2]]);
      check("instr", core_instr, im[pc[9:2]]);
      check("core_rst", 32'(core_rst), 32'(!m_run));
      tick();
      core_we = 0;
      if (m_run) begin
         cyc++;
         if (we && a == 32'hFFFF_FFFF && f3 == 3'b010) begin
            m_rv = 1;
            m_rp = wd == 1;
            m_run = 0;
         end else begin
            if (we) store_ref(a, f3, wd);
            if (cyc == TO) begin
               m_to = 1;
               m_run = 0;
            end
         end
      end
   endtask

   function automatic logic [31:0] rnd_addr;
      return ($urandom & 32'h7FFF_FC00) | 32'($urandom_range(0, 63));
   endfunction

   task automatic end_check;
      repeat (3) tick();
      check("result_valid", 32'(result_valid), 32'(m_rv));
      check("result_passed", 32'(result_passed), 32'(m_rp));
      check("timeout", 32'(timeout), 32'(m_to));
      check("prog_overflow", 32'(prog_overflow), 32'(m_ovf));
      check("cycle_count", cycle_count, 32'(cyc));
      check("core_rst_end", 32'(core_rst), 32'(!m_run));
      core_we = 0;
      for (int i = 0; i < WORDS; i++) begin
         core_pc = ($urandom & 32'hFFFF_FC00) | 32'(i << 2) | 32'($urandom_range(0, 3));
         core_mem_addr = ($urandom & 32'h7FFF_FC00) | 32'(i << 2) | 32'($urandom_range(0, 3));
         #1;
         check("imem_word", core_instr, im[i]);
         check("dmem_word", core_rdata, dm[i]);
      end
   endtask

   initial begin
      // clear, then program four instructions and pass
      start();
      for (int i = 0; i < 4; i++) beat(0, $urandom, i == 3);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 32'h40, 3'b010, 32'h1234_5678, 4);
      cycle(1, 32'hFFFF_FFFF, 3'b010, 1, 8);
      check("pass_valid", 32'(result_valid), 1);
      check("pass_passed", 32'(result_passed), 1);
      end_check();
      check("pass_cycles", cycle_count, 3);
      // failing result leaves data memory untouched
      start();
      beat(1, $urandom, 0);
      beat(1, $urandom, 0);
      beat(0, $urandom, 1);
      cycle(1, 32'hFFFF_FFFF, 3'b010, 2, 0);
      check("fail_valid", 32'(result_valid), 1);
      check("fail_passed", 32'(result_passed), 0);
      end_check();
      // partial stores into a programmed word
      start();
      beat(1, 32'h1122_3344, 0);
      beat(0, $urandom, 1);
      cycle(1, 1, 3'b000, 32'hDEAD_BEAB, 0);
      check("sb_addr1", core_rdata, 32'h1122_AB44);
      cycle(1, 2, 3'b001, 32'h5555_BEEF, 0);
      check("sh_addr2", core_rdata, 32'hBEEF_AB44);
      cycle(1, 3, 3'b001, 32'h5555_BEEF, 0);
      check("sh_addr3", core_rdata, 32'hEFEF_AB44);
      cycle(1, 0, 3'b011, 32'hFFFF_FFFF, 0);
      check("code11_nowrite", core_rdata, 32'hEFEF_AB44);
      cycle(1, 32'hFFFF_FFFF, 3'b010, 1, 0);
      end_check();
      // watchdog expiry
      start();
      beat(0, $urandom, 1);
      for (int j = 0; j < 20 && m_run; j++) cycle(0, 0, 0, 0, 0);
      check("wd_timeout", 32'(timeout), 1);
      check("wd_cycles", cycle_count, TO);
      end_check();
      // result on the expiry cycle wins
      start();
      beat(0, $urandom, 1);
      for (int j = 0; j < TO - 1; j++) cycle(0, 0, 0, 0, 0);
      cycle(1, 32'hFFFF_FFFF, 3'b010, 1, 0);
      check("tie_valid", 32'(result_valid), 1);
      check("tie_timeout", 32'(timeout), 0);
      end_check();
      // pointer wrap, then reset in the middle of RUN
      start();
      for (int i = 0; i < 257; i++) beat(0, 32'hA000_0000 + 32'(i), i == 256);
      check("ovf_flag", 32'(prog_overflow), 1);
      cycle(0, 0, 0, 0, 0);
      check("ovf_word0", core_instr, 32'hA000_0100);
      cycle(0, 0, 0, 0, 0);
      rst_n = 0;
      #1;
      check_idle_flags("midrun");
      // randomized sessions
      for (int s = 0; s < 8; s++) begin
         int nb, k;
         start();
         nb = $urandom_range(1, 12);
         for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            beat(1'($urandom_range(0, 1)), $urandom, i == nb - 1);
         end
         k = $urandom_range(0, 8);
         for (int j = 0; j < k && m_run; j++)
            cycle(1'($urandom_range(0, 1)), rnd_addr(), 3'($urandom_range(0, 7)), $urandom, $urandom);
         if ($urandom_range(0, 1) == 1)
            cycle(1, 32'hFFFF_FFFF, 3'b010, 32'($urandom_range(0, 2)), $urandom);
         for (int j = 0; j < 20 && m_run; j++) cycle(0, 0, 0, 0, $urandom);
         repeat (2) cycle(1, rnd_addr(), 3'($urandom_range(0, 7)), $urandom, $urandom);
         end_check();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
